// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: issues a read (0x03) or write (0x02) command,
// an address and up to MAX_BYTES data bytes, then reports completion.
module spi_mem_ctrl #(
  parameter int ADDR_BITS = 24,
  parameter int MAX_BYTES = 4,
  parameter int CLK_DIV   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             is_write,
  input  logic [ADDR_BITS-1:0]             target_address,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes,
  input  logic [8*MAX_BYTES-1:0]           wdata,
  output logic [8*MAX_BYTES-1:0]           rdata,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             sclk,
  output logic                             mosi,
  output logic                             cs,
  input  logic                             miso
);

  localparam int NBW = $clog2(MAX_BYTES+1);
  localparam int DW  = 8*MAX_BYTES;
  localparam int HDR = 8 + ADDR_BITS;
  localparam int TXW = HDR + DW;
  localparam int CW  = $clog2(TXW+1);
  localparam int VW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nx;
  logic            bad, wr;
  logic [NBW-1:0]  nb;
  logic [TXW-1:0]  tx;
  logic [DW-1:0]   rx;
  logic [CW-1:0]   bit_cnt, last;
  logic [VW-1:0]   div_cnt;
  logic            accept, div_end, shift_end;

  // Whole frame left-aligned; data bytes are only driven for writes.
  function automatic logic [TXW-1:0] build_tx(input logic w,
                                              input logic [ADDR_BITS-1:0] a,
                                              input logic [DW-1:0] d);
    logic [TXW-1:0] t;
    t = '0;
    t[TXW-1 -: 8]         = w ? 8'h02 : 8'h03;
    t[TXW-9 -: ADDR_BITS] = a;
    if (w)
      for (int j = 0; j < MAX_BYTES; j++)
        t[DW-1-8*j -: 8] = d[8*j +: 8];
    return t;
  endfunction

  // rx holds the received stream with the first bit at position 8*n-1.
  function automatic logic [DW-1:0] order_bytes(input logic [DW-1:0] sr,
                                                input logic [NBW-1:0] n);
    logic [DW-1:0] o;
    o = '0;
    for (int j = 0; j < MAX_BYTES; j++)
      if (j < int'(n))
        o[8*j +: 8] = sr[8*(int'(n)-1-j) +: 8];
    return o;
  endfunction

  assign accept    = (state == IDLE) && start && !busy;
  assign div_end   = (div_cnt == VW'(CLK_DIV-1));
  assign shift_end = (state == SHIFT) && div_end && sclk && (bit_cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // busy while in IDLE marks a request latched on the previous edge
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (busy) state_nx = bad ? FINISH : SHIFT;
      SHIFT:   if (shift_end) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rdata   <= '0;
      bad     <= 1'b0;
      wr      <= 1'b0;
      nb      <= '0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      last    <= '0;
      div_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            wr   <= is_write;
            nb   <= num_bytes;
            bad  <= (num_bytes == '0) || (num_bytes > NBW'(MAX_BYTES));
            tx   <= build_tx(is_write, target_address, wdata);
            rx   <= '0;
            last <= CW'(HDR-1) + CW'({num_bytes, 3'b000});
          end else if (busy && bad) begin
            done <= 1'b1;
            err  <= 1'b1;
          end else if (busy) begin
            cs      <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= tx[TXW-1];
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (bit_cnt >= CW'(HDR)) rx <= {rx[DW-2:0], miso};
            end else if (bit_cnt == last) begin
              sclk <= 1'b0;
              cs   <= 1'b1;
              mosi <= 1'b0;
              done <= 1'b1;
              if (!wr) rdata <= order_bytes(rx, nb);
            end else begin
              sclk    <= 1'b0;
              tx      <= {tx[TXW-2:0], 1'b0};
              mosi    <= tx[TXW-2];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        FINISH:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 24: number of address bits sent after the command byte.
REQ-002 Parameter MAX_BYTES, default 4: maximum data bytes per transaction, allowed range 1..8.
REQ-003 Parameter CLK_DIV, default 1: clk cycles per SCLK half-period, minimum 1.
REQ-004 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port start, input, 1: request pulse; sampled only in IDLE.
REQ-007 Port is_write, input, 1: 1 = write (cmd 0x02), 0 = read (cmd 0x03).
REQ-008 Port target_address, input, ADDR_BITS: memory byte address.
REQ-009 Port num_bytes, input, $clog2(MAX_BYTES+1): number of data bytes to transfer.
REQ-010 Port wdata, input, 8*MAX_BYTES: write data; byte 0 in bits [7:0].
REQ-011 Port rdata, output, 8*MAX_BYTES: read data; byte 0 in bits [7:0].
REQ-012 Port busy, output, 1: high from the cycle after acceptance until the done cycle, inclusive.
REQ-013 Port done, output, 1: one-cycle completion pulse.
REQ-014 Port err, output, 1: valid with done; 1 = request rejected.
REQ-015 Ports sclk (out, 1), mosi (out, 1), cs (out, 1, active-low) and miso (in, 1): SPI mode 0 bus.

Function
REQ-016 States: IDLE, SHIFT, FINISH; on reject, IDLE goes to FINISH directly.
REQ-017 IDLE with start=1: latch is_write, target_address, num_bytes and wdata; go to SHIFT next edge, or to FINISH with err=1 if num_bytes is 0 or greater than MAX_BYTES.
REQ-018 Shift stream, MSB-first within each field:
  - 8-bit command;
  - ADDR_BITS address bits;
  - num_bytes data bytes, byte 0 first, each byte MSB-first.
REQ-019 The bit count is N = 8 + ADDR_BITS + 8*num_bytes.
REQ-020 SHIFT entry edge: cs falls, sclk=0, and mosi presents the first bit.
REQ-021 Each bit has sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-022 Bit timing:
  - mosi changes only on the edge where sclk falls (or at SHIFT entry);
  - miso is sampled on the edge where sclk rises.
REQ-023 Read: miso bits during the data phase are assembled into rdata bytes in transfer order.
REQ-024 Read: rdata bytes at or above num_bytes are zeroed.
REQ-025 Write: miso is ignored and rdata is unchanged.
REQ-026 After the final high phase: sclk=0, cs=1, done=1 and err=0 on the same edge (FINISH); next edge returns to IDLE.
REQ-027 Latency: start sampled at edge k gives done at edge k+1+2*CLK_DIV*N.
REQ-028 For a rejected request, done=1 and err=1 at edge k+1.
REQ-029 start while busy, or in the FINISH cycle, is ignored and not queued.
REQ-030 rdata is updated only when a read completes successfully; it holds its value otherwise.
REQ-031 Address bits beyond ADDR_BITS do not exist; target_address is sent as-is with no wrap or increment logic.

Reset
REQ-032 rst_n low, asynchronously and at any point including mid-transfer, forces:
  - state=IDLE;
  - cs=1, sclk=0, mosi=0;
  - busy=0, done=0, err=0;
  - rdata=0;
  - all counters cleared.
REQ-033 After rst_n rises, the first start is accepted normally; no partial transfer resumes.

Verification
REQ-034 Defaults, read 4 bytes at 0x000010 with a slave returning EF,BE,AD,DE -> mosi 0x03,00,00,10; rdata=0xDEADBEEF; done 129 cycles after start; err=0.
REQ-035 Defaults, write 2 bytes at 0x000100 with wdata=0x00001234 -> mosi 0x02,00,01,00,34,12 (48 bits); done at +97; rdata unchanged.
REQ-036 num_bytes=0, then num_bytes=5 -> each gives done=1 and err=1 one cycle after start; cs stays 1 throughout.
REQ-037 start pulsed at cycle 10 of a read -> ignored; single transaction; exactly one done.
REQ-038 rst_n low during address bit 12 -> same cycle cs=1, sclk=0, busy=0; next start completes a full correct transfer.
REQ-039 CLK_DIV=3, read 1 byte -> each sclk phase is 3 cycles; done at +1+6*40=241; rdata[31:8]=0.
